// File: rtl/swipt_sequencer.sv
// SWIPT transmitter sequencer: frequency search handoff, settle/measure
// timing, duty tracking, comms override and heartbeat supervision.
module swipt_sequencer #(
    parameter int FREQ_W       = 20,
    parameter int DUTY_W       = 12,
    parameter int DEF_FREQ     = 36000,
    parameter int DEF_DUTY     = 200,
    parameter int DUTY_MIN     = 50,
    parameter int DUTY_MAX     = 500,
    parameter int STEP_DIV     = 10,
    parameter int SETTLE_LEN   = 5000000,
    parameter int MEAS_LEN     = 2000000,
    parameter int REOPT_PERIOD = 0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              swipt_alive,
    input  logic              comms_ctrl,
    input  logic [FREQ_W-1:0] comms_freq,
    input  logic [DUTY_W-1:0] comms_duty,
    input  logic              fa_done,
    input  logic [FREQ_W-1:0] fa_new_freq,
    input  logic [FREQ_W-1:0] fa_best_freq,
    input  logic              duty_rdy,
    input  logic              duty_down,
    input  logic              mean_req,
    input  logic              reopt_req,
    output logic [FREQ_W-1:0] freq,
    output logic [DUTY_W-1:0] duty,
    output logic [2:0]        phase,
    output logic              measure
);

    localparam int SM_MAX  = (SETTLE_LEN > MEAS_LEN) ? SETTLE_LEN : MEAS_LEN;
    localparam int LEN_MAX = (SM_MAX > REOPT_PERIOD) ? SM_MAX : REOPT_PERIOD;
    localparam int CNT_W   = $clog2(LEN_MAX) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_LEN - 1);
    localparam logic [CNT_W-1:0] REOPT_LAST  =
        CNT_W'((REOPT_PERIOD > 0) ? REOPT_PERIOD - 1 : 0);
    localparam logic             REOPT_ON    = (REOPT_PERIOD > 0);

    localparam logic [FREQ_W-1:0] F_DEF = FREQ_W'(DEF_FREQ);
    localparam logic [DUTY_W-1:0] D_DEF = DUTY_W'(DEF_DUTY);
    localparam logic [DUTY_W-1:0] D_MIN = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] D_MAX = DUTY_W'(DUTY_MAX);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FREQ   = 3'd1,
        SETTLE = 3'd2,
        MEAS   = 3'd3,
        TRACK  = 3'd4
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [FREQ_W-1:0]   freq_nx;
    logic [DUTY_W-1:0]   duty_nx;
    logic                meas_nx;
    // run holds IDLE one extra cycle after reset/heartbeat release
    logic                run, run_nx;

    logic [DUTY_W-1:0]        step_q, step;
    logic [DUTY_W:0]          up_sum;
    logic signed [DUTY_W+1:0] dn_sum;
    logic [DUTY_W-1:0]        duty_up, duty_dn, comms_clamp;

    // duty step arithmetic with saturation at both clamps
    assign step_q  = duty / DUTY_W'(STEP_DIV);
    assign step    = (step_q == '0) ? DUTY_W'(1) : step_q;
    assign up_sum  = {1'b0, duty} + {1'b0, step};
    assign dn_sum  = $signed({2'b00, duty}) - $signed({2'b00, step});
    assign duty_up = (up_sum > (DUTY_W+1)'(DUTY_MAX)) ? D_MAX
                                                      : up_sum[DUTY_W-1:0];
    assign duty_dn = (dn_sum < $signed((DUTY_W+2)'(DUTY_MIN))) ? D_MIN
                                                               : dn_sum[DUTY_W-1:0];
    assign comms_clamp = (comms_duty < D_MIN) ? D_MIN :
                         (comms_duty > D_MAX) ? D_MAX : comms_duty;

    assign phase = state;

    // next-state and registered-output values, reset/heartbeat first
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        freq_nx  = freq;
        duty_nx  = duty;
        meas_nx  = measure;
        run_nx   = 1'b1;
        if (!nrst || !swipt_alive) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            freq_nx  = F_DEF;
            duty_nx  = D_DEF;
            meas_nx  = 1'b0;
            run_nx   = 1'b0;
        end else if (comms_ctrl) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            freq_nx  = comms_freq;
            duty_nx  = comms_clamp;
            meas_nx  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nx  = '0;
                    meas_nx = 1'b0;
                    if (run) state_nx = FREQ;
                end
                FREQ: begin
                    meas_nx = 1'b0;
                    if (fa_done) begin
                        freq_nx  = fa_best_freq;
                        state_nx = SETTLE;
                        cnt_nx   = SETTLE_LAST;
                    end else begin
                        freq_nx = fa_new_freq;
                    end
                end
                SETTLE: begin
                    meas_nx = 1'b0;
                    if (cnt == '0) begin
                        state_nx = MEAS;
                        cnt_nx   = MEAS_LAST;
                        meas_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                MEAS: begin
                    if (cnt == '0) begin
                        state_nx = TRACK;
                        cnt_nx   = '0;
                        meas_nx  = 1'b0;
                    end else begin
                        cnt_nx  = cnt - 1'b1;
                        meas_nx = 1'b1;
                    end
                end
                TRACK: begin
                    meas_nx = mean_req;
                    if (duty_rdy) duty_nx = duty_down ? duty_dn : duty_up;
                    if (reopt_req || (REOPT_ON && cnt == REOPT_LAST)) begin
                        state_nx = FREQ;
                        cnt_nx   = '0;
                        meas_nx  = 1'b0;
                    end else if (REOPT_ON) begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    meas_nx  = 1'b0;
                end
            endcase
        end
    end

    // state and output registers; reset is folded into the next-state logic
    always_ff @(posedge clk) begin
        state   <= state_nx;
        cnt     <= cnt_nx;
        freq    <= freq_nx;
        duty    <= duty_nx;
        measure <= meas_nx;
        run     <= run_nx;
    end

endmodule

// File: tb/tb_swipt_sequencer.sv
// Self-checking bench for swipt_sequencer: directed literal checks plus
// randomized traffic compared every cycle against a behavioural model.
module tb_swipt_sequencer;

    localparam int SL = 4;
    localparam int ML = 8;
    localparam int RP = 16;

    logic        clk = 1'b0;
    logic        nrst, swipt_alive, comms_ctrl;
    logic [19:0] comms_freq, fa_new_freq, fa_best_freq;
    logic [11:0] comms_duty;
    logic        fa_done, duty_rdy, duty_down, mean_req, reopt_req;
    logic [19:0] freq;
    logic [11:0] duty;
    logic [2:0]  phase;
    logic        measure;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // behavioural model state
    int m_freq = 36000, m_duty = 200, m_ph = 0, m_meas = 0, m_el = 0;
    bit m_armed = 1'b0;

    swipt_sequencer #(
        .SETTLE_LEN  (SL),
        .MEAS_LEN    (ML),
        .REOPT_PERIOD(RP)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .swipt_alive (swipt_alive),
        .comms_ctrl  (comms_ctrl),
        .comms_freq  (comms_freq),
        .comms_duty  (comms_duty),
        .fa_done     (fa_done),
        .fa_new_freq (fa_new_freq),
        .fa_best_freq(fa_best_freq),
        .duty_rdy    (duty_rdy),
        .duty_down   (duty_down),
        .mean_req    (mean_req),
        .reopt_req   (reopt_req),
        .freq        (freq),
        .duty        (duty),
        .phase       (phase),
        .measure     (measure)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: one update per clock edge from the rules of each phase
    always @(posedge clk) begin
        int st;
        if (!nrst || !swipt_alive) begin
            m_freq = 36000; m_duty = 200; m_ph = 0; m_meas = 0; m_el = 0;
            m_armed = 1'b0;
        end else if (comms_ctrl) begin
            m_freq = int'(comms_freq);
            m_duty = (comms_duty < 50) ? 50 : (comms_duty > 500) ? 500
                                                                  : int'(comms_duty);
            m_ph = 0; m_meas = 0; m_el = 0;
            m_armed = 1'b1;
        end else begin
            case (m_ph)
                0: begin
                    m_meas = 0; m_el = 0;
                    if (m_armed) m_ph = 1;
                end
                1: begin
                    m_meas = 0;
                    if (fa_done) begin
                        m_freq = int'(fa_best_freq); m_ph = 2; m_el = 0;
                    end else begin
                        m_freq = int'(fa_new_freq);
                    end
                end
                2: begin
                    m_el++;
                    if (m_el == SL) begin m_ph = 3; m_el = 0; m_meas = 1; end
                end
                3: begin
                    m_el++;
                    if (m_el == ML) begin m_ph = 4; m_el = 0; m_meas = 0; end
                end
                default: begin
                    m_meas = int'(mean_req);
                    if (duty_rdy) begin
                        st = m_duty / 10;
                        if (st < 1) st = 1;
                        if (duty_down) m_duty = (m_duty - st < 50) ? 50 : m_duty - st;
                        else           m_duty = (m_duty + st > 500) ? 500 : m_duty + st;
                    end
                    m_el++;
                    if (reopt_req || m_el == RP) begin m_ph = 1; m_el = 0; m_meas = 0; end
                end
            endcase
            m_armed = 1'b1;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_freq",  int'(freq),    m_freq);
            check("m_duty",  int'(duty),    m_duty);
            check("m_phase", int'(phase),   m_ph);
            check("m_meas",  int'(measure), m_meas);
        end
    end

    task automatic quiet();
        comms_ctrl = 0; fa_done = 0; duty_rdy = 0; duty_down = 0;
        mean_req = 0; reopt_req = 0;
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while (int'(phase) != p && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("wait_phase", int'(phase), p);
    endtask

    // load a duty via override, then run the sequence up to phase p
    task automatic setup(input int d, input int p);
        quiet();
        comms_ctrl = 1; comms_duty = 12'(d); comms_freq = 20'd33000;
        @(negedge clk);
        comms_ctrl = 0; fa_done = 1; fa_best_freq = 20'd34000;
        @(negedge clk);
        @(negedge clk);
        fa_done = 0;
        wait_phase(p);
    endtask

    task automatic duty_step(input bit dn, input int exp, input string nm);
        duty_rdy = 1; duty_down = dn;
        @(negedge clk);
        duty_rdy = 0;
        check(nm, int'(duty), exp);
    endtask

    initial begin
        int n;
        nrst = 0; swipt_alive = 1; quiet();
        comms_freq = 0; comms_duty = 0; fa_new_freq = 0; fa_best_freq = 0;
        @(negedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        check("rst_freq",  int'(freq), 36000);
        check("rst_duty",  int'(duty), 200);
        check("rst_phase", int'(phase), 0);
        check("rst_meas",  int'(measure), 0);
        nrst = 1;
        @(negedge clk);
        check("rel_idle", int'(phase), 0);
        @(negedge clk);
        check("rel_freq", int'(phase), 1);

        fa_new_freq = 20'd30000;
        repeat (2) @(negedge clk);
        check("new_freq", int'(freq), 30000);
        fa_done = 1; fa_best_freq = 20'd35500;
        @(negedge clk);
        fa_done = 0;
        check("best_freq", int'(freq), 35500);
        check("settle_ph", int'(phase), 2);
        n = 0;
        while (phase == 3'd2 && n < 50) begin n++; @(negedge clk); end
        check("settle_len", n, 4);
        n = 0;
        while (measure && n < 50) begin n++; @(negedge clk); end
        check("meas_len", n, 8);
        check("track_ph", int'(phase), 4);
        duty_step(0, 220, "up_200");

        setup(480, 4); duty_step(0, 500, "sat_max");
        setup(52, 4);  duty_step(1, 50,  "sat_min");
        setup(200, 4); duty_step(1, 180, "down_200");

        setup(200, 4);
        n = 0;
        while (phase == 3'd4 && n < 50) begin n++; @(negedge clk); end
        check("reopt_len", n, 16);
        check("reopt_ph", int'(phase), 1);

        setup(200, 4);
        reopt_req = 1; duty_rdy = 1; duty_down = 0;
        @(negedge clk);
        reopt_req = 0; duty_rdy = 0;
        check("coin_duty", int'(duty), 220);
        check("coin_ph", int'(phase), 1);

        setup(300, 3);
        repeat (3) @(negedge clk);
        comms_ctrl = 1; comms_freq = 20'd40000; comms_duty = 12'd600;
        @(negedge clk);
        check("ovr_freq", int'(freq), 40000);
        check("ovr_duty", int'(duty), 500);
        check("ovr_meas", int'(measure), 0);
        check("ovr_ph", int'(phase), 0);
        comms_ctrl = 0;
        @(negedge clk);
        check("ovr_rel", int'(phase), 1);

        setup(350, 4);
        check("hb_pre", int'(duty), 350);
        swipt_alive = 0;
        @(negedge clk);
        swipt_alive = 1;
        check("hb_duty", int'(duty), 200);
        check("hb_freq", int'(freq), 36000);
        check("hb_ph", int'(phase), 0);
        check("hb_meas", int'(measure), 0);

        repeat (4000) begin
            @(negedge clk);
            nrst        = ($urandom_range(0, 299) != 0);
            swipt_alive = ($urandom_range(0, 299) != 0);
            if (comms_ctrl) comms_ctrl = ($urandom_range(0, 2) != 0);
            else            comms_ctrl = ($urandom_range(0, 59) == 0);
            comms_freq   = 20'($urandom);
            comms_duty   = 12'($urandom_range(0, 700));
            fa_done      = ($urandom_range(0, 9) == 0);
            fa_new_freq  = 20'($urandom);
            fa_best_freq = 20'($urandom);
            duty_rdy     = ($urandom_range(0, 3) == 0);
            duty_down    = 1'($urandom);
            mean_req     = 1'($urandom);
            reopt_req    = ($urandom_range(0, 29) == 0);
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/swipt_sequencer.md
SWIPT_SEQUENCER -- requirements
Module: swipt_sequencer

Interface
REQ-001 The block SHALL take the following parameters (name, default, meaning):
- FREQ_W, 20, frequency word width.
- DUTY_W, 12, duty word width.
- DEF_FREQ, 36000, frequency after reset or heartbeat loss.
- DEF_DUTY, 200, duty after reset or heartbeat loss.
- DUTY_MIN, 50, lower duty clamp.
- DUTY_MAX, 500, upper duty clamp.
- STEP_DIV, 10, duty step divisor (step = duty/STEP_DIV).
- SETTLE_LEN, 5000000, SETTLE phase length in cycles (>=1).
- MEAS_LEN, 2000000, MEAS phase length in cycles (>=1).
- REOPT_PERIOD, 0, TRACK cycles before automatic re-optimisation; 0 disables.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock.
- nrst, in, 1, reset; synchronous, active-low.
- swipt_alive, in, 1, heartbeat valid.
- comms_ctrl, in, 1, comms override request.
- comms_freq, in, FREQ_W, override frequency.
- comms_duty, in, DUTY_W, override duty.
- fa_done, in, 1, frequency search finished.
- fa_new_freq, in, FREQ_W, candidate frequency under search.
- fa_best_freq, in, FREQ_W, search result.
- duty_rdy, in, 1, duty adjust strobe (one cycle).
- duty_down, in, 1, 1 = decrease duty, 0 = increase duty.
- mean_req, in, 1, data block's measure request.
- reopt_req, in, 1, external re-optimise strobe.
- freq, out, FREQ_W, frequency to the output stage.
- duty, out, DUTY_W, duty to the output stage.
- phase, out, 3, current state.
- measure, out, 1, mean-current measurement enable.

Function
REQ-003 The block SHALL be fully synchronous to clk, with all outputs registered.
REQ-004 Input priority per cycle SHALL be: (~nrst | ~swipt_alive) > comms_ctrl > state machine.
REQ-005 State encodings SHALL be IDLE=0, FREQ=1, SETTLE=2, MEAS=3, TRACK=4; codes 5-7 SHALL return to IDLE on the next cycle.
REQ-006 IDLE SHALL go to FREQ on the next cycle.
REQ-007 In FREQ with fa_done=0, freq SHALL be loaded from fa_new_freq each cycle.
REQ-008 In FREQ with fa_done=1, freq SHALL be loaded from fa_best_freq, the state SHALL go to SETTLE, and the counter SHALL be loaded with SETTLE_LEN-1.
REQ-009 In SETTLE, measure SHALL be 0 and the counter SHALL decrement each cycle.
REQ-010 When the SETTLE counter is 0, the state SHALL go to MEAS, the counter SHALL be loaded with MEAS_LEN-1, and measure SHALL be set to 1.
REQ-011 measure SHALL be high for exactly MEAS_LEN consecutive cycles.
REQ-012 At MEAS count 0, the state SHALL go to TRACK, the counter SHALL be cleared, and measure SHALL be cleared to 0.
REQ-013 In TRACK, measure SHALL follow mean_req with one cycle of latency.
REQ-014 In TRACK, duty_rdy=1 SHALL update duty on the next cycle:
- step = max(1, duty/STEP_DIV), integer division.
- Increase: duty+step, computed in DUTY_W+1 bits and saturated to DUTY_MAX.
- Decrease: duty-step, computed signed and saturated to DUTY_MIN.
REQ-015 duty_rdy outside TRACK SHALL be ignored.
REQ-016 In TRACK with REOPT_PERIOD>0, the counter SHALL increment each cycle; reaching REOPT_PERIOD-1 SHALL cause the next state to be FREQ.
REQ-017 reopt_req=1 in TRACK SHALL cause the next state to be FREQ regardless of REOPT_PERIOD.
REQ-018 reopt_req outside TRACK SHALL be ignored.
REQ-019 If a re-optimise trigger and duty_rdy coincide in TRACK, both the duty update and the transition to FREQ SHALL take effect.
REQ-020 On re-optimisation, duty SHALL be retained and freq SHALL keep its value until FREQ loads a new one.
REQ-021 While comms_ctrl=1:
- freq SHALL be loaded from comms_freq.
- duty SHALL be loaded from comms_duty clamped to [DUTY_MIN, DUTY_MAX].
- phase SHALL be IDLE, measure SHALL be 0, and counters SHALL be cleared.
REQ-022 On comms_ctrl falling, the state machine SHALL restart from IDLE, reaching FREQ one cycle later.
REQ-023 Counter width SHALL be $clog2 of the largest of SETTLE_LEN, MEAS_LEN and REOPT_PERIOD, plus 1.

Reset
REQ-024 When nrst=0 or swipt_alive=0 at a clock edge, the next cycle SHALL have freq=DEF_FREQ, duty=DEF_DUTY, phase=IDLE, measure=0 and counters=0.
REQ-025 Reset or heartbeat loss mid-SETTLE or mid-MEAS SHALL abort the phase with no residual measure pulse.
REQ-026 After release, phase SHALL reach FREQ two cycles after the first alive edge.

Verification
REQ-027 Reset: nrst=0 for 3 cycles -> freq=36000, duty=200, phase=0, measure=0; after release, phase=1 on the second edge.
REQ-028 Search handoff (SETTLE_LEN=4, MEAS_LEN=8): fa_new_freq=30000 for 2 cycles, then fa_done=1 with fa_best_freq=35500 -> freq=35500, phase=2 for 4 cycles, measure high for exactly 8 cycles, then phase=4.
REQ-029 Duty saturation:
- duty=480, duty_rdy with duty_down=0 -> duty=500.
- duty=52, duty_rdy with duty_down=1 -> duty=50.
- duty=200, duty_down=0 -> 220; duty=200, duty_down=1 -> 180.
REQ-030 Override mid-MEAS: comms_ctrl=1, comms_freq=40000, comms_duty=600 -> next cycle freq=40000, duty=500, measure=0, phase=0; release -> phase=1 one cycle later.
REQ-031 Re-optimise (REOPT_PERIOD=16): phase=FREQ after 16 TRACK cycles; reopt_req coinciding with duty_rdy (duty_down=0, duty=200) -> duty=220 and phase=1.
REQ-032 Heartbeat loss in TRACK with duty=350: swipt_alive=0 -> duty=200, freq=36000, phase=0, measure=0.
